mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped I/O responder on the processor's data-memory port (`address_dmem`/`data`/`wren`). It claims a 4-word window at the top of the 12-bit dmem space and serves reads with the same one-cycle registered latency as the synchronous dmem RAM. Writes to the TX register feed a small output FIFO, which drains over a valid/ready byte stream to a console/UART transmitter. It also provides a free-running cycle counter and a scratch register for directed processor test programs.

## Interface
- `MMIO_BASE`, default 12'hFFC: word address of the window; the low 2 bits must be 0.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of two, ≥2.
- `clock` in 1: the single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low; all state clears while low.
- `address_dmem` in 12: processor dmem word address.
- `data` in 32: processor store data.
- `wren` in 1: store strobe, sampled at the rising edge.
- `q_mmio` out 32: read data; registered.
- `mmio_hit` out 1: registered; high when `q_mmio` must override the RAM `q`.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: sink accepts the head byte.

## Operation
- Hit decode: `address_dmem[11:2] == MMIO_BASE[11:2]`. Offset = `address_dmem[1:0]`. Non-hit accesses are ignored entirely.
- Offset 0, TXDATA:
  - Write pushes `data[7:0]`.
  - Read returns 0.
- Offset 1, STATUS (read):
  - bit0: full
  - bit1: empty
  - bits[4:2]: count (0..FIFO_DEPTH, saturating at 7)
  - bit5: overflow, sticky
  - other bits: 0
- Offset 1, STATUS (write): writing with `data[5]=1` clears overflow. Other bits are ignored.
- Offset 2, CYCLE:
  - 32-bit counter, increments every cycle and wraps from 0xFFFFFFFF to 0.
  - Write loads `data`.
- Offset 3, SCRATCH: plain 32-bit read/write register.
- Push while full and no pop in the same cycle: the byte is dropped and overflow is set.
- Push while full with a pop in the same cycle: the push is accepted and count is unchanged.
- Pop occurs at an edge where `tx_valid & tx_ready`.
- Push and pop in the same cycle when non-full: count is unchanged, and the head advances in order.
- Reset values:
  - `q_mmio` = 0, `mmio_hit` = 0
  - `tx_valid` = 0, `tx_data` = 0
  - FIFO empty, overflow = 0
  - CYCLE = 0, SCRATCH = 0

## Timing
- Read latency is 1 cycle. Address at edge N gives `q_mmio`/`mmio_hit` valid after edge N+1.
- This matches dmem, so the pipeline's existing M/W timing is unchanged.
- Reads sample register state before the same-edge update (read-old-value). STATUS read in the cycle of a push shows the pre-push count.
- Write to CYCLE at edge N: the counter equals `data` after N, then `data+1` after N+1. The load overrides the increment.
- Push at edge N: `tx_valid` rises after N. There is no combinational bypass from `data` to `tx_data`.
- `tx_data`/`tx_valid` come from registered state only. No combinational path from `tx_ready` to any output.
- Reset is asynchronous assert and synchronous release (the deasserting edge is outside this block's scope). Reset asserted mid-stream discards FIFO contents immediately.

## Structure
- Shared header `mmio_defs.vh` holds:
  - offset constants `MMIO_TXDATA`/`STATUS`/`CYCLE`/`SCRATCH`
  - STATUS bit positions
  - default `MMIO_BASE`
- One sub-module, `mmio_fifo`:
  - parameterised by depth and width
  - push/pop/full/empty/count
  - same-cycle push+pop legal at any fill level
- Top level holds address decode, CYCLE, SCRATCH, overflow, and the read-data register.
- Integration: the dmem read-mux uses `mmio_hit` to select `q_mmio` over the RAM output.

## Test plan
- **Reset and counter:** hold `reset` low 3 cycles, release, then read 0xFFE. Expect `q_mmio` = 0, `mmio_hit` = 1 one cycle later, `tx_valid` = 0. A second read 5 cycles later returns the first value + 5.
- **FIFO order:** with `tx_ready` = 0, write 0x41, 0x42, 0x43 to 0xFFC, then read STATUS. Expect 0x0C (count 3). Raise `tx_ready`: `tx_data` shows 0x41, 0x42, 0x43 on consecutive cycles, then `tx_valid` = 0 and STATUS = 0x02.
- **Overflow:** with `tx_ready` = 0, do 5 pushes with DEPTH = 4. Expect STATUS = 0x31 (full, count 4, overflow) and the 5th byte absent from the drain. Write 0x20 to 0xFFD; STATUS then reads 0x11.
- **Full push+pop:** fill to 4, then push 0x55 with `tx_ready` = 1 in the same cycle. Count stays 4, overflow stays 0, and 0x55 drains last.
- **CYCLE wrap:** write 0xFFFFFFFE to 0xFFE, then read 2 cycles later. Expect 0x00000000 (wrap), and SCRATCH write/read of 0xDEADBEEF round-trips.
- **Non-hit access:** write to 0xFFB with `wren` = 1. Expect `mmio_hit` = 0 and no state change. Assert `reset` mid-drain: `tx_valid` drops immediately and the FIFO is empty after release.

Source files
------------

// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register offsets, STATUS layout, default window.
package mmio_responder_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [ADDR_W-1:0] MMIO_BASE_DEFAULT = 12'hFFC;

  localparam logic [1:0] MMIO_TXDATA  = 2'd0;
  localparam logic [1:0] MMIO_STATUS  = 2'd1;
  localparam logic [1:0] MMIO_CYCLE   = 2'd2;
  localparam logic [1:0] MMIO_SCRATCH = 2'd3;

  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_COUNT_LO = 2;
  localparam int unsigned ST_OVF      = 5;

  // Assemble the STATUS read word; unused bits read as zero.
  function automatic logic [DATA_W-1:0] status_word(input logic full, input logic empty,
                                                    input logic [2:0] count, input logic ovf);
    logic [DATA_W-1:0] w;
    w = '0;
    w[ST_FULL]                    = full;
    w[ST_EMPTY]                   = empty;
    w[ST_COUNT_LO+2:ST_COUNT_LO]  = count;
    w[ST_OVF]                     = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Power-of-two circular FIFO; same-cycle push+pop is legal at any fill level.
module mmio_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Four-word MMIO window on the dmem port: TX FIFO, STATUS, free-running CYCLE, SCRATCH.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [11:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_mmio,
  output logic              mmio_hit,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic              hit;
  logic [1:0]        offset;
  logic              wr_tx;
  logic              wr_status;
  logic              wr_cycle;
  logic              wr_scratch;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [2:0]        count_sat;
  logic              pop;
  logic              overflow;
  logic [DATA_W-1:0] cycle_cnt;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] rd_word;

  assign hit        = (address_dmem[11:2] == MMIO_BASE[11:2]);
  assign offset     = address_dmem[1:0];
  assign wr_tx      = hit && wren && (offset == MMIO_TXDATA);
  assign wr_status  = hit && wren && (offset == MMIO_STATUS);
  assign wr_cycle   = hit && wren && (offset == MMIO_CYCLE);
  assign wr_scratch = hit && wren && (offset == MMIO_SCRATCH);
  assign pop        = tx_ready && !fifo_empty;
  assign tx_valid   = !fifo_empty;
  assign count_sat  = (32'(fifo_count) > 32'd7) ? 3'd7 : 3'(fifo_count);

  mmio_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(BYTE_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .wdata (data[BYTE_W-1:0]),
    .rdata (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read mux over pre-edge state, so reads see the old value.
  always_comb begin
    rd_word = '0;
    unique case (offset)
      MMIO_TXDATA:  rd_word = '0;
      MMIO_STATUS:  rd_word = status_word(fifo_full, fifo_empty, count_sat, overflow);
      MMIO_CYCLE:   rd_word = cycle_cnt;
      MMIO_SCRATCH: rd_word = scratch;
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_mmio    <= '0;
      mmio_hit  <= 1'b0;
      overflow  <= 1'b0;
      cycle_cnt <= '0;
      scratch   <= '0;
    end else begin
      mmio_hit <= hit;
      q_mmio   <= hit ? rd_word : '0;
      if (wr_tx && fifo_full && !pop)        overflow <= 1'b1;
      else if (wr_status && data[ST_OVF])    overflow <= 1'b0;
      cycle_cnt <= wr_cycle ? data : cycle_cnt + 32'd1;
      if (wr_scratch) scratch <= data;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder with hand-computed expectations.
module tb_mmio_responder;

  logic        clock;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_mmio;
  logic        mmio_hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_cmp = 0;
  int n_err = 0;

  mmio_responder #(.MMIO_BASE(12'hFFC), .FIFO_DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_mmio       (q_mmio),
    .mmio_hit     (mmio_hit),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply bus inputs now (at a negedge) and advance past one rising edge.
  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic we, input logic rdy);
    address_dmem = a;
    data         = d;
    wren         = we;
    tx_ready     = rdy;
    @(negedge clock);
  endtask

  initial begin
    address_dmem = 12'h000;
    data         = '0;
    wren         = 1'b0;
    tx_ready     = 1'b0;
    reset        = 1'b1;
    #1 reset = 1'b0;

    // Reset and counter
    repeat (3) @(negedge clock);
    chk("rst_q",     q_mmio,          32'h0);
    chk("rst_hit",   32'(mmio_hit),   32'h0);
    chk("rst_valid", 32'(tx_valid),   32'h0);
    chk("rst_txd",   32'(tx_data),    32'h0);
    reset = 1'b1;
    step(12'hFFE, 0, 1'b0, 1'b0);
    chk("cyc_first", q_mmio,          32'd0);
    chk("cyc_hit",   32'(mmio_hit),   32'h1);
    chk("cyc_valid", 32'(tx_valid),   32'h0);
    repeat (5) @(negedge clock);
    chk("cyc_plus5", q_mmio,          32'd5);

    // FIFO order
    step(12'hFFC, 32'h41, 1'b1, 1'b0);
    step(12'hFFC, 32'h42, 1'b1, 1'b0);
    step(12'hFFC, 32'h43, 1'b1, 1'b0);
    step(12'hFFD, 0, 1'b0, 1'b0);
    chk("ord_status", q_mmio,         32'h0C);
    chk("ord_head0",  32'(tx_data),   32'h41);
    tx_ready = 1'b1; address_dmem = 12'h000;
    @(negedge clock); chk("ord_head1", 32'(tx_data), 32'h42);
    @(negedge clock); chk("ord_head2", 32'(tx_data), 32'h43);
    @(negedge clock); chk("ord_empty", 32'(tx_valid), 32'h0);
    step(12'hFFD, 0, 1'b0, 1'b0);
    chk("ord_status_e", q_mmio,       32'h02);

    // Overflow: fifth push is dropped and sets the sticky flag
    for (int i = 1; i <= 5; i++) step(12'hFFC, 32'(i), 1'b1, 1'b0);
    step(12'hFFD, 0, 1'b0, 1'b0);
    chk("ovf_status", q_mmio,         32'h31);
    step(12'hFFD, 32'h20, 1'b1, 1'b0);
    chk("ovf_readold", q_mmio,        32'h31);
    step(12'hFFD, 0, 1'b0, 1'b0);
    chk("ovf_cleared", q_mmio,        32'h11);
    tx_ready = 1'b1; address_dmem = 12'h000;
    chk("ovf_d1", 32'(tx_data), 32'h01);
    @(negedge clock); chk("ovf_d2", 32'(tx_data), 32'h02);
    @(negedge clock); chk("ovf_d3", 32'(tx_data), 32'h03);
    @(negedge clock); chk("ovf_d4", 32'(tx_data), 32'h04);
    @(negedge clock); chk("ovf_drained", 32'(tx_valid), 32'h0);

    // Full push+pop in the same cycle
    for (int i = 0; i < 4; i++) step(12'hFFC, 32'h11 + 32'(i), 1'b1, 1'b0);
    step(12'hFFC, 32'h55, 1'b1, 1'b1);
    step(12'hFFD, 0, 1'b0, 1'b0);
    chk("pp_status", q_mmio, 32'h11);
    tx_ready = 1'b1; address_dmem = 12'h000;
    chk("pp_d1", 32'(tx_data), 32'h12);
    @(negedge clock); chk("pp_d2", 32'(tx_data), 32'h13);
    @(negedge clock); chk("pp_d3", 32'(tx_data), 32'h14);
    @(negedge clock); chk("pp_d4", 32'(tx_data), 32'h55);
    @(negedge clock); chk("pp_drained", 32'(tx_valid), 32'h0);

    // CYCLE load and wrap, TXDATA read, SCRATCH round trip
    step(12'hFFE, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(12'hFFE, 0, 1'b0, 1'b0);
    chk("wrap_load", q_mmio, 32'hFFFF_FFFE);
    @(negedge clock); chk("wrap_max",  q_mmio, 32'hFFFF_FFFF);
    @(negedge clock); chk("wrap_zero", q_mmio, 32'h0000_0000);
    step(12'hFFC, 0, 1'b0, 1'b0);
    chk("txdata_rd", q_mmio, 32'h0);
    chk("txdata_hit", 32'(mmio_hit), 32'h1);
    step(12'hFFF, 0, 1'b0, 1'b0);
    chk("scr_reset", q_mmio, 32'h0);
    step(12'hFFF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(12'hFFF, 0, 1'b0, 1'b0);
    chk("scr_rt", q_mmio, 32'hDEAD_BEEF);

    // Non-hit access changes nothing
    step(12'hFFB, 32'h1234_5678, 1'b1, 1'b0);
    chk("nohit_hit", 32'(mmio_hit), 32'h0);
    chk("nohit_q",   q_mmio,        32'h0);
    step(12'hFFF, 0, 1'b0, 1'b0);
    chk("nohit_scr", q_mmio, 32'hDEAD_BEEF);
    step(12'hFFD, 0, 1'b0, 1'b0);
    chk("nohit_status", q_mmio, 32'h02);

    // Reset mid-stream discards the FIFO at once
    step(12'hFFC, 32'h77, 1'b1, 1'b0);
    step(12'hFFC, 32'h78, 1'b1, 1'b0);
    step(12'h000, 0, 1'b0, 1'b1);
    chk("mid_valid", 32'(tx_valid), 32'h1);
    #1 reset = 1'b0;
    #1 chk("mid_rst_valid", 32'(tx_valid), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    step(12'hFFD, 0, 1'b0, 1'b0);
    chk("post_rst_status", q_mmio, 32'h02);
    chk("post_rst_valid", 32'(tx_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
